ddr5_cmd_scheduler: RTL and testbench

//  Memory-clock-domain command scheduler between the front-end request FIFO and the DDR5 CA/CS pins.

---
 rtl/ddr5_cmd_scheduler_if.sv | 28 ++
 rtl/ddr5_cmd_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_ddr5_cmd_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr5_cmd_scheduler_if.sv
// Request-FIFO, CA/CS command and data-phase strobe signals of the DDR5 command scheduler.
// master = request source / pin monitor side, slave = scheduler.
`timescale 1ns/1ps
interface ddr5_cmd_scheduler_if;
   logic        req_empty;
   logic        req_rd_en;
   logic [31:0] req_addr;
   logic        req_we;
   logic [31:0] req_wdata;
   logic [3:0]  req_strb;
   logic [13:0] CA;
   logic        CS;
   logic        wdata_valid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        rd_capture;
   logic        busy;

   modport master (
      output req_empty, req_addr, req_we, req_wdata, req_strb,
      input  req_rd_en, CA, CS, wdata_valid, wdata, wstrb, rd_capture, busy
   );

   modport slave (
      input  req_empty, req_addr, req_we, req_wdata, req_strb,
      output req_rd_en, CA, CS, wdata_valid, wdata, wstrb, rd_capture, busy
   );
endinterface

// File: rtl/ddr5_cmd_scheduler.sv
// DDR5 command scheduler: pops one request, issues PRE/ACT/RD/WR two-beat CA commands, inserts refresh.
// Latency: first command beat 2 cycles after the pop; data strobe T_CWL/T_CL after RD/WR beat2.
// Backpressure: req_rd_en only in IDLE with no refresh pending; one request in flight at a time.
`timescale 1ns/1ps
module ddr5_cmd_scheduler #(
   parameter int T_RCD  = 4,
   parameter int T_RP   = 4,
   parameter int T_CL   = 6,
   parameter int T_CWL  = 4,
   parameter int T_RFC  = 20,
   parameter int T_REFI = 390
) (
   input logic              mem_clk,
   input logic              rst,
   ddr5_cmd_scheduler_if.slave bus
);
   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_CHK       = 4'd1;
   localparam logic [3:0] S_PRE       = 4'd2;
   localparam logic [3:0] S_WAIT_RP   = 4'd3;
   localparam logic [3:0] S_ACT       = 4'd4;
   localparam logic [3:0] S_WAIT_RCD  = 4'd5;
   localparam logic [3:0] S_RW        = 4'd6;
   localparam logic [3:0] S_WAIT_DATA = 4'd7;
   localparam logic [3:0] S_PREA      = 4'd8;
   localparam logic [3:0] S_WAIT_PREA = 4'd9;
   localparam logic [3:0] S_REF       = 4'd10;
   localparam logic [3:0] S_WAIT_RFC  = 4'd11;

   logic [3:0]  state;
   logic        beat2;
   logic [15:0] gap;
   logic [15:0] ref_cnt;
   logic        ref_pend;
   logic [3:0]  bank_open;
   logic [13:0] open_row [4];
   logic [25:0] addr_q;
   logic        we_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;

   logic [1:0]  bank;
   logic [13:0] row;
   logic [9:0]  col;
   logic        ref_wrap;
   logic        gap_done;
   logic        pop;
   logic        unused_addr_hi;

   assign bank     = addr_q[11:10];
   assign row      = addr_q[25:12];
   assign col      = addr_q[9:0];
   assign ref_wrap = (ref_cnt == 16'(T_REFI - 1));
   assign gap_done = (gap == 16'd0);
   assign pop      = (state == S_IDLE) && !ref_pend && !bus.req_empty;
   assign unused_addr_hi = ^bus.req_addr[31:26];

   always_ff @(posedge mem_clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         beat2     <= 1'b0;
         gap       <= '0;
         ref_cnt   <= '0;
         ref_pend  <= 1'b0;
         bank_open <= '0;
         for (int i = 0; i < 4; i++) open_row[i] <= '0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         ref_cnt <= ref_wrap ? 16'd0 : ref_cnt + 16'd1;
         // A wrap landing on the last RFC cycle must not be lost by the clear.
         if (ref_wrap)
            ref_pend <= 1'b1;
         else if (state == S_WAIT_RFC && gap_done)
            ref_pend <= 1'b0;

         case (state)
            S_IDLE: begin
               if (ref_pend) begin
                  state <= (|bank_open) ? S_PREA : S_REF;
               end else if (!bus.req_empty) begin
                  addr_q <= bus.req_addr[25:0];
                  we_q   <= bus.req_we;
                  if (bus.req_we) begin
                     wdata_q <= bus.req_wdata;
                     wstrb_q <= bus.req_strb;
                  end
                  state <= S_CHK;
               end
            end
            S_CHK: begin
               if (!bank_open[bank])
                  state <= S_ACT;
               else if (open_row[bank] == row)
                  state <= S_RW;
               else
                  state <= S_PRE;
            end
            S_PRE: begin
               beat2 <= ~beat2;
               if (beat2) begin
                  bank_open[bank] <= 1'b0;
                  gap   <= 16'(T_RP - 1);
                  state <= S_WAIT_RP;
               end
            end
            S_WAIT_RP: begin
               if (gap_done) state <= S_ACT;
               else          gap   <= gap - 16'd1;
            end
            S_ACT: begin
               beat2 <= ~beat2;
               if (beat2) begin
                  bank_open[bank] <= 1'b1;
                  open_row[bank]  <= row;
                  gap   <= 16'(T_RCD - 1);
                  state <= S_WAIT_RCD;
               end
            end
            S_WAIT_RCD: begin
               if (gap_done) state <= S_RW;
               else          gap   <= gap - 16'd1;
            end
            S_RW: begin
               beat2 <= ~beat2;
               if (beat2) begin
                  gap   <= we_q ? 16'(T_CWL - 1) : 16'(T_CL - 1);
                  state <= S_WAIT_DATA;
               end
            end
            S_WAIT_DATA: begin
               if (gap_done) state <= S_IDLE;
               else          gap   <= gap - 16'd1;
            end
            S_PREA: begin
               beat2 <= ~beat2;
               if (beat2) begin
                  bank_open <= '0;
                  gap   <= 16'(T_RP - 1);
                  state <= S_WAIT_PREA;
               end
            end
            S_WAIT_PREA: begin
               if (gap_done) state <= S_REF;
               else          gap   <= gap - 16'd1;
            end
            S_REF: begin
               beat2 <= ~beat2;
               if (beat2) begin
                  gap   <= 16'(T_RFC - 1);
                  state <= S_WAIT_RFC;
               end
            end
            S_WAIT_RFC: begin
               if (gap_done) begin
                  bank_open <= '0;
                  state     <= S_IDLE;
               end else begin
                  gap <= gap - 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // CA/CS decode straight from state so an async reset silences the pins immediately.
   logic        cmd;
   logic [2:0]  op;
   logic [1:0]  cbank;
   logic [13:0] payload;

   always_comb begin
      cmd     = 1'b1;
      op      = 3'b000;
      cbank   = bank;
      payload = '0;
      case (state)
         S_ACT:  begin op = 3'b001; payload = row; end
         S_RW:   begin op = we_q ? 3'b011 : 3'b010; payload = {4'd0, col}; end
         S_PRE:  op = 3'b100;
         S_PREA: begin op = 3'b110; cbank = 2'd0; end
         S_REF:  begin op = 3'b101; cbank = 2'd0; end
         default: cmd = 1'b0;
      endcase
   end

   assign bus.CA          = !cmd ? 14'd0 : (beat2 ? payload : {op, cbank, 9'd0});
   assign bus.CS          = cmd && !beat2;
   assign bus.req_rd_en   = pop;
   assign bus.wdata_valid = (state == S_WAIT_DATA) && gap_done && we_q;
   assign bus.rd_capture  = (state == S_WAIT_DATA) && gap_done && !we_q;
   assign bus.wdata       = wdata_q;
   assign bus.wstrb       = wstrb_q;
   assign bus.busy        = (state != S_IDLE);
endmodule

// File: tb/tb_ddr5_cmd_scheduler.sv
// Self-checking bench for ddr5_cmd_scheduler: directed scenarios plus random requests against a
// per-bank open-row model that predicts the per-cycle pin schedule of each request.
`timescale 1ns/1ps
module tb_ddr5_cmd_scheduler;
   localparam int T_RCD = 4;
   localparam int T_RP  = 4;
   localparam int T_CL  = 6;
   localparam int T_CWL = 4;
   localparam int T_RFC = 20;

   logic mem_clk = 1'b0;
   logic rst;
   always #5 mem_clk = ~mem_clk;

   ddr5_cmd_scheduler_if bus();
   ddr5_cmd_scheduler_if bus2();

   ddr5_cmd_scheduler #(.T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL), .T_CWL(T_CWL),
                        .T_RFC(T_RFC), .T_REFI(390))
      dut (.mem_clk(mem_clk), .rst(rst), .bus(bus));

   ddr5_cmd_scheduler #(.T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL), .T_CWL(T_CWL),
                        .T_RFC(T_RFC), .T_REFI(50))
      dut2 (.mem_clk(mem_clk), .rst(rst), .bus(bus2));

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_ref    = 0;
   logic        mdl_open [4];
   logic [13:0] mdl_row  [4];
   logic [13:0] first_ca;

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         mdl_open[i] = 1'b0;
         mdl_row[i]  = '0;
      end
   endtask

   // Presents one request (after pre_idle empty cycles), watches refreshes while waiting for the
   // pop, then checks every pin cycle from the pop until the scheduler is back in IDLE.
   task automatic do_req(input logic [31:0] addr, input logic we, input logic [31:0] data,
                         input logic [3:0] strb, input int pre_idle);
      logic [1:0]  bk;
      logic [13:0] rw;
      logic [9:0]  cl;
      logic [13:0] eca;
      logic        ecs, hit, miss, popped, prea_seen, any_open;
      logic [18:0] exp_v, got_v;
      int          t, pre_at, act_at, rw_at, str_at;
      bk = addr[11:10]; rw = addr[25:12]; cl = addr[9:0];
      @(posedge mem_clk); #1;
      bus.req_empty = (pre_idle == 0) ? 1'b0 : 1'b1;
      bus.req_addr = addr; bus.req_we = we; bus.req_wdata = data; bus.req_strb = strb;
      popped = 1'b0; prea_seen = 1'b0;
      for (int k = 0; k < 400 && !popped; k++) begin
         @(negedge mem_clk);
         if (bus.req_rd_en) begin
            popped = 1'b1;
         end else if (bus.CS && bus.CA[13:11] == 3'b110) begin
            prea_seen = 1'b1;
         end else if (bus.CS && bus.CA[13:11] == 3'b101) begin
            any_open = mdl_open[0] | mdl_open[1] | mdl_open[2] | mdl_open[3];
            n_checks++;
            if (prea_seen !== any_open) begin
               n_fail++;
               $display("FAIL refresh_prea: PREA before REF=%0b, required %0b", prea_seen, any_open);
            end
            model_clear();
            prea_seen = 1'b0;
            n_ref++;
         end
         if (!popped && k + 1 == pre_idle) begin
            @(posedge mem_clk); #1;
            bus.req_empty = 1'b0;
         end
      end
      if (!popped) begin
         n_checks++; n_fail++;
         $display("FAIL pop_timeout: no req_rd_en for addr %h, required a pop", addr);
         bus.req_empty = 1'b1;
         return;
      end
      hit  = mdl_open[bk] && (mdl_row[bk] == rw);
      miss = mdl_open[bk] && !hit;
      t = 2; pre_at = -10; act_at = -10;
      if (miss) begin pre_at = t; t = t + 2 + T_RP; end
      if (!hit) begin act_at = t; t = t + 2 + T_RCD; end
      rw_at  = t;
      str_at = rw_at + 1 + (we ? T_CWL : T_CL);
      mdl_open[bk] = 1'b1;
      mdl_row[bk]  = rw;
      for (int o = 0; o <= str_at + 1; o++) begin
         if (o == 1) begin
            @(posedge mem_clk); #1;
            bus.req_empty = 1'b1;
            bus.req_addr = $urandom; bus.req_we = 1'($urandom); bus.req_wdata = $urandom;
            bus.req_strb = 4'($urandom);
         end
         if (o > 0) @(negedge mem_clk);
         eca = '0; ecs = 1'b0;
         if (o == pre_at) begin eca = {3'b100, bk, 9'd0}; ecs = 1'b1; end
         if (o == act_at) begin eca = {3'b001, bk, 9'd0}; ecs = 1'b1; end
         if (o == act_at + 1) eca = rw;
         if (o == rw_at) begin eca = {(we ? 3'b011 : 3'b010), bk, 9'd0}; ecs = 1'b1; end
         if (o == rw_at + 1) eca = {4'd0, cl};
         exp_v = {(o == 0), (o >= 1 && o <= str_at), ecs, (we && o == str_at),
                  (!we && o == str_at), eca};
         got_v = {bus.req_rd_en, bus.busy, bus.CS, bus.wdata_valid, bus.rd_capture, bus.CA};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL req_cycle addr=%h we=%0b o=%0d: {rd_en,busy,cs,wv,rc,ca}=%h, required %h",
                     addr, we, o, got_v, exp_v);
         end
         if (o == 2) first_ca = bus.CA;
         if (we && o == str_at) begin
            n_checks++;
            if ({bus.wdata, bus.wstrb} !== {data, strb}) begin
               n_fail++;
               $display("FAIL wdata: got %h/%h, required %h/%h", bus.wdata, bus.wstrb, data, strb);
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [54:0] v;
      rst = 1'b1;
      repeat (3) @(posedge mem_clk);
      @(negedge mem_clk);
      v = {bus.CA, bus.CS, bus.req_rd_en, bus.wdata_valid, bus.rd_capture, bus.busy,
           bus.wdata, bus.wstrb};
      n_checks++;
      if (v !== '0) begin
         n_fail++;
         $display("FAIL reset_hold: outputs=%h, required 0", v);
      end
      @(posedge mem_clk); #1;
      rst = 1'b0;
      @(negedge mem_clk);
      v = {bus.CA, bus.CS, bus.req_rd_en, bus.wdata_valid, bus.rd_capture, bus.busy,
           bus.wdata, bus.wstrb};
      n_checks++;
      if (v !== '0) begin
         n_fail++;
         $display("FAIL reset_release: outputs=%h, required 0", v);
      end
      model_clear();
   endtask

   task automatic test_write_closed_bank();
      do_req(32'h0000_4567, 1'b1, 32'h1425_3679, 4'hF, 0);
      n_checks++;
      if (first_ca !== 14'h0A00) begin
         n_fail++;
         $display("FAIL write_act_beat1: CA=%h, required 0a00", first_ca);
      end
   endtask

   task automatic test_read_hit();
      do_req(32'h0000_4567, 1'b0, 32'h0, 4'h0, 2);
      n_checks++;
      if (first_ca !== 14'h1200) begin
         n_fail++;
         $display("FAIL read_hit_beat1: CA=%h, required 1200", first_ca);
      end
   endtask

   task automatic test_row_conflict();
      do_req(32'h0001_4567, 1'b0, 32'h0, 4'h0, 1);
      n_checks++;
      if (first_ca !== 14'h2200) begin
         n_fail++;
         $display("FAIL row_conflict_pre: CA=%h, required 2200", first_ca);
      end
   endtask

   task automatic test_reset_mid_cmd();
      logic popped;
      logic [18:0] v;
      @(posedge mem_clk); #1;
      bus.req_empty = 1'b0; bus.req_addr = 32'h0000_4C67; bus.req_we = 1'b1;
      bus.req_wdata = 32'hCAFE_F00D; bus.req_strb = 4'h3;
      popped = 1'b0;
      for (int k = 0; k < 100 && !popped; k++) begin
         @(negedge mem_clk);
         popped = bus.req_rd_en;
      end
      @(posedge mem_clk); #1;
      bus.req_empty = 1'b1;
      if (!popped) begin
         n_checks++; n_fail++;
         $display("FAIL reset_mid_pop_timeout: no req_rd_en, required a pop");
      end
      repeat (4) @(negedge mem_clk);
      #2 rst = 1'b1;
      #1;
      v = {bus.req_rd_en, bus.busy, bus.CS, bus.wdata_valid, bus.rd_capture, bus.CA};
      n_checks++;
      if (v !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_immediate: outputs=%h, required 0", v);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge mem_clk);
         n_checks++;
         if ({bus.CS, bus.CA} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_mid_no_wr: CS/CA=%h, required 0", {bus.CS, bus.CA});
         end
      end
      @(posedge mem_clk); #1;
      rst = 1'b0;
      model_clear();
      do_req(32'h0000_4C67, 1'b1, 32'hCAFE_F00D, 4'h3, 0);
      n_checks++;
      if (first_ca !== 14'h0E00) begin
         n_fail++;
         $display("FAIL reset_mid_reissue_act: CA=%h, required 0e00", first_ca);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int i = 0; i < 40; i++) begin
         a = {6'($urandom), 14'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 10'($urandom)};
         do_req(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3));
      end
      n_checks++;
      if (n_ref == 0) begin
         n_fail++;
         $display("FAIL random_refresh_seen: refreshes=%0d, required at least 1", n_ref);
      end
   endtask

   task automatic test_refresh();
      logic        found, prev_rd_en, ecs;
      logic [13:0] eca;
      logic [18:0] exp_v, got_v;
      int          at;
      @(posedge mem_clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge mem_clk);
      #1;
      rst = 1'b0;
      bus2.req_empty = 1'b0; bus2.req_addr = 32'h0000_5803; bus2.req_we = 1'b0;
      found = 1'b0; prev_rd_en = 1'b0; at = -1;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge mem_clk);
         if (bus2.CS && bus2.CA == 14'h3000) begin
            found = 1'b1; at = k;
         end else begin
            prev_rd_en = bus2.req_rd_en;
         end
      end
      n_checks++;
      if (!found || at < 50 || at > 80) begin
         n_fail++;
         $display("FAIL refresh_prea_time: PREA at cycle %0d, required within 50..80", at);
      end
      if (found) begin
         n_checks++;
         if (prev_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL refresh_priority: req_rd_en before PREA=%0b, required 0", prev_rd_en);
         end
         for (int o = 0; o <= 30; o++) begin
            if (o > 0) @(negedge mem_clk);
            eca = '0; ecs = 1'b0;
            if (o == 0)  begin eca = 14'h3000; ecs = 1'b1; end
            if (o == 6)  begin eca = 14'h2800; ecs = 1'b1; end
            if (o == 30) begin eca = 14'h0C00; ecs = 1'b1; end
            exp_v = {(o == 28), (o != 28), ecs, 1'b0, 1'b0, eca};
            got_v = {bus2.req_rd_en, bus2.busy, bus2.CS, bus2.wdata_valid, bus2.rd_capture, bus2.CA};
            n_checks++;
            if (got_v !== exp_v) begin
               n_fail++;
               $display("FAIL refresh_seq o=%0d: {rd_en,busy,cs,wv,rc,ca}=%h, required %h",
                        o, got_v, exp_v);
            end
         end
      end
      @(posedge mem_clk); #1;
      bus2.req_empty = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      bus.req_empty = 1'b1; bus.req_addr = '0; bus.req_we = 1'b0;
      bus.req_wdata = '0; bus.req_strb = '0;
      bus2.req_empty = 1'b1; bus2.req_addr = '0; bus2.req_we = 1'b0;
      bus2.req_wdata = '0; bus2.req_strb = '0;
      first_ca = '0;
      model_clear();
      test_reset();
      test_write_closed_bank();
      test_read_hit();
      test_row_conflict();
      test_reset_mid_cmd();
      test_random();
      test_refresh();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
